ahb_bridge_arbiter: RTL

- Round-robin, burst-aware arbiter that shares the single AHB-to-APB bridge slave port among N AHB requesters.
- Owns hgrant/hmaster selection. A separate mux uses hmaster to steer haddr/hwrite/hwdata/hburst/htrans into the bridge.
- Grants change only on hready-high boundaries, never inside a fixed-length burst or a locked sequence.
- Sits between the master-side request logic and the bridge's hreadyout.

---
 rtl/ahb_arb_pkg.sv | 38 +++
 rtl/ahb_bridge_arbiter_rr_picker.sv | 32 +++
 rtl/ahb_bridge_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB bridge arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {PARK, ARB, SINGLE, FIXED, INCR, LOCKED} arb_state_t;

  // One bit per htrans code; set where the code moves data (NONSEQ, SEQ).
  localparam logic [3:0] HTRANS_ACTIVE = 4'b1100;

  // Beats in a burst; 0 marks the undefined-length INCR.
  function automatic logic [4:0] burst_len(input hburst_t b);
    case (b)
      HB_SINGLE:          return 5'd1;
      HB_INCR:            return 5'd0;
      HB_WRAP4, HB_INCR4: return 5'd4;
      HB_WRAP8, HB_INCR8: return 5'd8;
      default:            return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after the pointer, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan ptr+1 .. ptr+N so the last owner is considered last.
  always_comb begin : pick
    int   w_c;
    logic w_found;
    w_c      = 0;
    w_found  = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      w_c = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_c]) begin
        w_found       = 1'b1;
        o_idx         = IW'(w_c);
        o_onehot[w_c] = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Burst-aware round-robin arbiter for the shared AHB-to-APB bridge port.
// The burst class is taken from the owner's first completed beat, so a
// fresh tenure always starts in SINGLE and is promoted to FIXED/INCR there.
module ahb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DEF_MASTER  = 0,
  parameter int MAX_HOLD    = 16
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [NUM_MASTERS-1:0]         hbusreq,
  input  logic [NUM_MASTERS-1:0]         hlock,
  input  logic [1:0]                     htrans,
  input  logic [2:0]                     hburst,
  input  logic                           hready,
  output logic [NUM_MASTERS-1:0]         hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
  output logic                           hmastlock
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [NUM_MASTERS-1:0] DEF_OH  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;
  localparam logic [MW-1:0]          DEF_IDX = MW'(DEF_MASTER);

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [MW-1:0]          r_gidx;
  logic [MW-1:0]          r_master;
  logic                   r_mastlock;
  logic [MW-1:0]          r_rr_ptr;
  logic [4:0]             r_beat_cnt;
  logic [4:0]             r_blen;
  logic [HW-1:0]          r_hold_cnt;

  logic                   w_beat;
  logic                   w_own_req;
  logic                   w_own_lock;
  logic                   w_others;
  logic                   w_hold_hit;
  logic [4:0]             w_first_len;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic [MW-1:0]          w_win_idx;
  logic                   w_any;

  assign w_beat      = hready & HTRANS_ACTIVE[htrans];
  assign w_own_req   = hbusreq[r_gidx];
  assign w_own_lock  = hlock[r_gidx];
  assign w_others    = |(hbusreq & ~r_grant);
  assign w_hold_hit  = w_others && (r_hold_cnt == HW'(MAX_HOLD - 1));
  assign w_first_len = burst_len(hburst_t'(hburst));

  rr_picker #(.N(NUM_MASTERS), .IW(MW)) u_pick (
    .i_req    (hbusreq),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  // Arbitration FSM; everything freezes while the bridge stalls (hready=0).
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state    <= PARK;
      r_grant    <= DEF_OH;
      r_gidx     <= DEF_IDX;
      r_master   <= DEF_IDX;
      r_mastlock <= 1'b0;
      r_rr_ptr   <= DEF_IDX;
      r_beat_cnt <= '0;
      r_blen     <= 5'd1;
      r_hold_cnt <= '0;
    end else if (hready) begin
      // Data phase owner trails the address phase owner by one beat slot.
      r_master <= r_gidx;
      case (r_state)
        PARK: begin
          if (|hbusreq) r_state <= ARB;
        end
        ARB: begin
          r_beat_cnt <= '0;
          r_hold_cnt <= '0;
          if (w_any) begin
            r_grant  <= w_win_oh;
            r_gidx   <= w_win_idx;
            r_rr_ptr <= w_win_idx;
            if (hlock[w_win_idx]) begin
              r_state    <= LOCKED;
              r_mastlock <= 1'b1;
            end else begin
              r_state <= SINGLE;
            end
          end else begin
            r_grant <= DEF_OH;
            r_gidx  <= DEF_IDX;
            r_state <= PARK;
          end
        end
        SINGLE: begin
          if (w_beat) begin
            r_beat_cnt <= 5'd1;
            if (hburst == HB_INCR) begin
              if (w_hold_hit) begin
                r_state <= ARB;
              end else begin
                r_state <= INCR;
                if (w_others) r_hold_cnt <= r_hold_cnt + HW'(1);
              end
            end else if (w_first_len > 5'd1) begin
              r_blen  <= w_first_len;
              r_state <= FIXED;
            end else begin
              r_state <= ARB;
            end
          end else if (!w_own_req && htrans == HT_IDLE) begin
            // Granted master walked away before its first beat.
            r_state <= ARB;
          end
        end
        FIXED: begin
          if (w_beat) begin
            if (r_beat_cnt == r_blen - 5'd1) r_state <= ARB;
            else                             r_beat_cnt <= r_beat_cnt + 5'd1;
          end
        end
        INCR: begin
          if (w_own_lock) begin
            // A lock request outranks both release and the hold timeout.
            r_state    <= LOCKED;
            r_mastlock <= 1'b1;
          end else if (htrans == HT_IDLE || !w_own_req) begin
            r_state <= ARB;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 5'd1;
            if (w_others) begin
              if (w_hold_hit) r_state <= ARB;
              else            r_hold_cnt <= r_hold_cnt + HW'(1);
            end
          end
        end
        LOCKED: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 5'd1;
            if (!w_own_lock) begin
              r_state    <= ARB;
              r_mastlock <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= PARK;
          r_grant    <= DEF_OH;
          r_gidx     <= DEF_IDX;
          r_mastlock <= 1'b0;
        end
      endcase
    end
  end

  assign hgrant    = r_grant;
  assign hmaster   = r_master;
  assign hmastlock = r_mastlock;

endmodule
